// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcode constants, FSM state type and tag width for alu_seq
package alu_seq_pkg;
  localparam int TAG_W = 5;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SLL = 3'd1, OP_SLT = 3'd2, OP_SLTU = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_SR = 3'd5, OP_OR = 3'd6, OP_AND = 3'd7;
  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational RV base integer ALU (op[3] selects sub/sra, op[2:0] base opcode)
// Ports: op (4) opcode, a/b (XLEN) operands, y (XLEN) result.
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);
  localparam int SH_W = $clog2(XLEN);
  logic [SH_W-1:0] sh;
  logic [XLEN-1:0] sra_v;
  assign sh = b[SH_W-1:0];
  // kept apart so the arithmetic shift is evaluated in a signed-only expression
  assign sra_v = $signed(a) >>> sh;
  always_comb begin
    y = '0;
    case (op[2:0])
      OP_ADD:  y = op[3] ? a - b : a + b;
      OP_SLL:  y = a << sh;
      OP_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR:  y = a ^ b;
      OP_SR:   y = op[3] ? sra_v : a >> sh;
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute unit, base ALU plus optional iterative RV M-extension engine
// Ports: clk, reset (async, active-high); in_valid/in_ready/in_op/in_a/in_b/in_tag accept side;
//        out_valid/out_ready/out_d/out_tag/out_illegal result side.
// Define ALU_SEQ_MULDIV_EN to build the multiply/divide path; otherwise M ops return illegal.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_d,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  state_t state, nxt;
  logic acc, go_busy, last, acc_ill;
  logic [XLEN-1:0] core_y, acc_d, fix_d;
  alu_core #(.XLEN(XLEN)) u_core (.op(in_op[3:0]), .a(in_a), .b(in_b), .y(core_y));
  assign acc = in_valid && in_ready;
`ifdef ALU_SEQ_MULDIV_EN
  logic [2:0] f3, fn;
  logic [XLEN-1:0] hi, lo, mb, q_n, r_n;
  logic [CNT_W-1:0] cnt;
  logic neg, neg_r, sgn_a, sgn_b, zero_mul, div0, ovf, dge;
  logic [XLEN:0] msum, dsh, dsub;
  logic [2*XLEN-1:0] prod;
  // hi/lo hold {product high, multiplier} for mul and {remainder, dividend/quotient} for div
  always_comb begin
    f3 = in_op[2:0];
    sgn_a = in_a[XLEN-1] & (f3 == F_MULH || f3 == F_MULHSU || f3 == F_DIV || f3 == F_REM);
    sgn_b = in_b[XLEN-1] & (f3 == F_MULH || f3 == F_DIV || f3 == F_REM);
    zero_mul = !f3[2] && (in_a == '0 || in_b == '0);
    div0 = f3[2] && in_b == '0;
    ovf = (f3 == F_DIV || f3 == F_REM) && in_a == {1'b1, {(XLEN-1){1'b0}}} && in_b == '1;
    go_busy = in_op[4] && !(zero_mul || div0 || ovf);
    acc_ill = 1'b0;
    acc_d = !in_op[4] ? core_y : zero_mul ? '0 : div0 ? (f3[1] ? in_a : '1) : (f3[1] ? '0 : in_a);
    msum = {1'b0, hi} + (lo[0] ? {1'b0, mb} : '0);
    dsh = {hi, lo[XLEN-1]};
    dsub = dsh - {1'b0, mb};
    dge = dsh >= {1'b0, mb};
    prod = neg ? -{hi, lo} : {hi, lo};
    q_n = neg ? -lo : lo;
    r_n = neg_r ? -hi : hi;
    fix_d = fn[2] ? (fn[1] ? r_n : q_n) : (fn == F_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    last = cnt == CNT_W'(1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hi <= '0;
      lo <= '0;
      mb <= '0;
      cnt <= '0;
      neg <= 1'b0;
      neg_r <= 1'b0;
      fn <= '0;
    end else if (acc && go_busy) begin
      hi <= '0;
      lo <= sgn_a ? -in_a : in_a;
      mb <= sgn_b ? -in_b : in_b;
      cnt <= CNT_W'(XLEN);
      neg <= sgn_a ^ sgn_b;
      neg_r <= sgn_a;
      fn <= f3;
    end else if (state == BUSY) begin
      cnt <= cnt - CNT_W'(1);
      hi <= fn[2] ? (dge ? dsub[XLEN-1:0] : dsh[XLEN-1:0]) : msum[XLEN:1];
      lo <= fn[2] ? {lo[XLEN-2:0], dge} : {msum[0], lo[XLEN-1:1]};
    end
`else
  always_comb begin
    go_busy = 1'b0;
    last = 1'b0;
    acc_ill = in_op[4];
    acc_d = in_op[4] ? '0 : core_y;
    fix_d = '0;
  end
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == BUSY ? (last ? FIX : BUSY) :
          state == FIX ? DONE :
          acc ? (go_busy ? BUSY : DONE) :
          (state == DONE && out_ready) ? IDLE : state;
  always_comb begin
    in_ready = state == IDLE || (state == DONE && out_ready);
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_d <= '0;
      out_tag <= '0;
      out_illegal <= 1'b0;
    end else if (acc) begin
      out_tag <= in_tag;
      out_illegal <= acc_ill;
      if (!go_busy) out_d <= acc_d;
    end else if (state == FIX) out_d <= fix_d;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector scoreboard bench for alu_seq (XLEN=32)
module tb_alu_seq;
  typedef struct {
    logic [31:0] d;
    logic [4:0] tag;
    logic ill;
    int lat;
    int t;
  } exp_t;
  logic clk = 0, reset = 1, in_valid = 0, in_ready, out_valid, out_ready = 1, out_illegal;
  logic [4:0] in_op = 0, in_tag = 0, out_tag;
  logic [31:0] in_a = 0, in_b = 0, out_d;
  int cyc = 0, ncmp = 0, nbad = 0, w;
  bit seen = 0;
  exp_t q[$];
  alu_seq #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_d(out_d), .out_tag(out_tag), .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // starts at a negedge, returns at the negedge after the accept edge
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] d, input logic ill,
                      input int lat, output int waited);
    waited = 0;
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    #1;
    while (!in_ready && waited < 100) begin
      @(negedge clk); #1; waited++;
    end
    if (!in_ready) begin
      ncmp++; nbad++;
      $display("FAIL accept_timeout tag %0d: in_ready stayed 0", tag);
    end else q.push_back('{d, tag, ill, lat, cyc});
    @(negedge clk);
    in_valid = 0; in_op = 5'h1f; in_a = 32'hdead_beef; in_b = 32'h1234_5678; in_tag = 5'h1f;
  endtask
  task automatic sendm(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] d, input int lat);
    int ww;
`ifdef ALU_SEQ_MULDIV_EN
    send(op, a, b, tag, d, 1'b0, lat, ww);
`else
    send(op, a, b, tag, 32'h0, 1'b1, 1, ww);
`endif
  endtask
  always @(negedge clk) begin
    #2;
    if (reset) seen = 0;
    else if (out_valid) begin
      if (q.size() == 0) begin
        ncmp++; nbad++;
        $display("FAIL unexpected_output: tag %0h d %0h with nothing outstanding", out_tag, out_d);
      end else begin
        if (!seen) chk($sformatf("latency tag %0d", q[0].tag), 64'(cyc - q[0].t), 64'(q[0].lat));
        seen = 1;
        chk($sformatf("out_d tag %0d", q[0].tag), {32'h0, out_d}, {32'h0, q[0].d});
        chk($sformatf("out_tag tag %0d", q[0].tag), {59'h0, out_tag}, {59'h0, q[0].tag});
        chk($sformatf("out_illegal tag %0d", q[0].tag), {63'h0, out_illegal}, {63'h0, q[0].ill});
        if (out_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end
  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk); #1;
    chk("reset in_ready", {63'h0, in_ready}, 64'h1);
    chk("reset out_valid", {63'h0, out_valid}, 64'h0);
    chk("reset out_d", {32'h0, out_d}, 64'h0);
    chk("reset out_tag", {59'h0, out_tag}, 64'h0);
    chk("reset out_illegal", {63'h0, out_illegal}, 64'h0);
    @(negedge clk);
`ifdef ALU_SEQ_MULDIV_EN
    in_valid = 1; in_op = 5'b10100; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd2;
    #1;
    chk("middiv in_ready", {63'h0, in_ready}, 64'h1);
    @(negedge clk);
    in_valid = 0;
    repeat (9) begin
      chk("middiv out_valid", {63'h0, out_valid}, 64'h0);
      @(negedge clk);
    end
    reset = 1;
    #1;
    chk("middiv reset out_valid", {63'h0, out_valid}, 64'h0);
    @(negedge clk);
    reset = 0;
    @(negedge clk); #1;
    chk("middiv after in_ready", {63'h0, in_ready}, 64'h1);
    chk("middiv after out_valid", {63'h0, out_valid}, 64'h0);
    @(negedge clk);
`endif
    send(5'b00000, 32'd3, 32'd4, 5'd1, 32'd7, 1'b0, 1, w);
    send(5'b01000, 32'd5, 32'd7, 5'd3, 32'hffff_fffe, 1'b0, 1, w);
    chk("sweep no bubble sub", 64'(w), 64'h0);
    send(5'b01101, 32'h8000_0000, 32'd4, 5'd4, 32'hf800_0000, 1'b0, 1, w);
    chk("sweep no bubble sra", 64'(w), 64'h0);
    send(5'b00011, 32'd1, 32'hffff_ffff, 5'd5, 32'd1, 1'b0, 1, w);
    chk("sweep no bubble sltu", 64'(w), 64'h0);
    send(5'b00001, 32'd1, 32'd31, 5'd6, 32'h8000_0000, 1'b0, 1, w);
    send(5'b00010, 32'hffff_ffff, 32'd1, 5'd7, 32'd1, 1'b0, 1, w);
    send(5'b00101, 32'h8000_0000, 32'd4, 5'd8, 32'h0800_0000, 1'b0, 1, w);
    send(5'b00110, 32'hf0, 32'h0f, 5'd10, 32'hff, 1'b0, 1, w);
    send(5'b00111, 32'hf0, 32'h3c, 5'd11, 32'h30, 1'b0, 1, w);
    sendm(5'b10001, 32'h8000_0000, 32'h8000_0000, 5'd12, 32'h4000_0000, 34);
    sendm(5'b10010, 32'hffff_ffff, 32'hffff_ffff, 5'd13, 32'hffff_ffff, 34);
    sendm(5'b10011, 32'hffff_ffff, 32'hffff_ffff, 5'd14, 32'hffff_fffe, 34);
    sendm(5'b10000, 32'd3, 32'd3, 5'd15, 32'd9, 34);
    sendm(5'b10000, 32'd0, 32'd5, 5'd16, 32'd0, 1);
    sendm(5'b10100, 32'd7, 32'd0, 5'd17, 32'hffff_ffff, 1);
    sendm(5'b10110, 32'd7, 32'd0, 5'd18, 32'd7, 1);
    sendm(5'b10100, 32'h8000_0000, 32'hffff_ffff, 5'd19, 32'h8000_0000, 1);
    sendm(5'b10110, 32'h8000_0000, 32'hffff_ffff, 5'd20, 32'd0, 1);
    sendm(5'b10100, 32'hffff_fff9, 32'd2, 5'd21, 32'hffff_fffd, 34);
    sendm(5'b10110, 32'hffff_fff9, 32'd2, 5'd22, 32'hffff_ffff, 34);
    sendm(5'b10101, 32'd100, 32'd7, 5'd23, 32'd14, 34);
    sendm(5'b10111, 32'd100, 32'd7, 5'd24, 32'd2, 34);
    n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    out_ready = 0;
    send(5'b00111, 32'hf0, 32'h3c, 5'd9, 32'h30, 1'b0, 1, w);
    repeat (5) begin
      #1;
      chk("backpressure in_ready", {63'h0, in_ready}, 64'h0);
      @(negedge clk);
    end
    out_ready = 1;
    send(5'b00100, 32'hff00, 32'h0ff0, 5'd25, 32'hf0f0, 1'b0, 1, w);
    chk("backpressure same-cycle accept", 64'(w), 64'h0);
    sendm(5'b10000, 32'd3, 32'd3, 5'd26, 32'd9, 34);
    send(5'b00111, 32'hf0, 32'h3c, 5'd27, 32'h30, 1'b0, 1, w);
    n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      ncmp++; nbad++;
      $display("FAIL drain: %0d results never arrived", q.size());
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
